// File: rtl/rv_mem_pkg.sv
// Shared types and constants for the single-port RAM controller.
package rv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD     = 2'd1,
    RMW_WR = 2'd2,
    WACK   = 2'd3
  } mem_state_e;

  localparam logic [3:0] BE_FULL = 4'hF;
  localparam logic [3:0] BE_NONE = 4'h0;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

endpackage

// File: rtl/mem_byte_merge.sv
// Byte-lane merge: each lane takes new_word when its enable is set, else old_word.
module mem_byte_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  be,
  output logic [31:0] merged
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// Shares one RAM port between instruction fetch and the LSU; partial stores
// become read-modify-write sequences because the RAM has no byte enables.
//
// state  | meaning
// IDLE   | arbitrate; issue read, full write, or RMW read for the winner
// RD     | read data returned to the granted requester with its ack
// RMW_WR | merged word written back to the latched address
// WACK   | store complete, ls_ack pulsed
module mem_port_ctrl
  import rv_mem_pkg::*;
#(
  parameter int ADDR_LEN = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [31:0]         if_addr,
  output logic                if_ack,
  output logic [31:0]         if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [3:0]          ls_be,
  input  logic [31:0]         ls_addr,
  input  logic [31:0]         ls_wdata,
  output logic                ls_ack,
  output logic [31:0]         ls_rdata,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic                mem_wr_req,
  output logic [31:0]         mem_wr_data,
  input  logic [31:0]         mem_rd_data
);

  mem_state_e          state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                last_ls_q, last_ls_d;
  logic [ADDR_LEN-1:0] lat_addr_q;
  logic [3:0]          lat_be_q;
  logic [31:0]         lat_wdata_q;
  logic                lat_en;
  logic                win_if, win_ls;
  logic [ADDR_LEN-1:0] if_waddr, ls_waddr;
  logic [31:0]         merged_word;
  logic                unused_addr_bits;

  assign if_waddr = if_addr[ADDR_LEN+1:2];
  assign ls_waddr = ls_addr[ADDR_LEN+1:2];
  assign unused_addr_bits = ^{if_addr[31:ADDR_LEN+2], if_addr[1:0],
                              ls_addr[31:ADDR_LEN+2], ls_addr[1:0]};

  assign win_if = if_req & (~ls_req | last_ls_q);
  assign win_ls = ls_req & ~win_if;

  mem_byte_merge u_merge (
    .old_word (mem_rd_data),
    .new_word (lat_wdata_q),
    .be       (lat_be_q),
    .merged   (merged_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= REQ_IF;
      last_ls_q   <= 1'b0;
      lat_addr_q  <= '0;
      lat_be_q    <= '0;
      lat_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_ls_q <= last_ls_d;
      if (lat_en) begin
        lat_addr_q  <= ls_waddr;
        lat_be_q    <= ls_be;
        lat_wdata_q <= ls_wdata;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_ls_d   = last_ls_q;
    lat_en      = 1'b0;
    if_ack      = 1'b0;
    ls_ack      = 1'b0;
    if_rdata    = '0;
    ls_rdata    = '0;
    mem_addr    = '0;
    mem_wr_req  = 1'b0;
    mem_wr_data = '0;
    // Outputs are combinational from state and live inputs, so reset must
    // also gate them directly to kill an in-flight write strobe at once.
    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          if (win_if) begin
            mem_addr  = if_waddr;
            gnt_d     = REQ_IF;
            last_ls_d = 1'b0;
            state_d   = RD;
          end else if (win_ls) begin
            mem_addr  = ls_waddr;
            gnt_d     = REQ_LS;
            last_ls_d = 1'b1;
            if (!ls_we) begin
              state_d = RD;
            end else if (ls_be == BE_FULL) begin
              mem_wr_req  = 1'b1;
              mem_wr_data = ls_wdata;
              state_d     = WACK;
            end else if (ls_be == BE_NONE) begin
              state_d = WACK;
            end else begin
              lat_en  = 1'b1;
              state_d = RMW_WR;
            end
          end
        end
        RD: begin
          if (gnt_q == REQ_IF) begin
            if_ack   = 1'b1;
            if_rdata = mem_rd_data;
          end else begin
            ls_ack   = 1'b1;
            ls_rdata = mem_rd_data;
          end
          state_d = IDLE;
        end
        RMW_WR: begin
          mem_addr    = lat_addr_q;
          mem_wr_req  = 1'b1;
          mem_wr_data = merged_word;
          state_d     = WACK;
        end
        WACK: begin
          ls_ack  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Bench for mem_port_ctrl: behavioural RAM, word-level reference memory,
// directed cases plus randomized single and contending traffic.
module tb_mem_port_ctrl;

  localparam int ADDR_LEN = 11;
  localparam int DEPTH    = 1 << ADDR_LEN;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                if_req;
  logic [31:0]         if_addr;
  logic                if_ack;
  logic [31:0]         if_rdata;
  logic                ls_req;
  logic                ls_we;
  logic [3:0]          ls_be;
  logic [31:0]         ls_addr;
  logic [31:0]         ls_wdata;
  logic                ls_ack;
  logic [31:0]         ls_rdata;
  logic [ADDR_LEN-1:0] mem_addr;
  logic                mem_wr_req;
  logic [31:0]         mem_wr_data;
  logic [31:0]         mem_rd_data;

  logic                bd_we;
  logic [ADDR_LEN-1:0] bd_addr;
  logic [31:0]         bd_data;

  logic [31:0] ram     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  int n_chk = 0;
  int n_err = 0;
  int n_wr = 0;
  int n_lsack = 0;
  logic [31:0]         last_rdata;
  logic [ADDR_LEN-1:0] last_addr;

  int  cyc, last_cyc, n_if, n_ls, gap, idx, acks0;
  bit  exp_ls;

  mem_port_ctrl #(.ADDR_LEN(ADDR_LEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_ack      (if_ack),
    .if_rdata    (if_rdata),
    .ls_req      (ls_req),
    .ls_we       (ls_we),
    .ls_be       (ls_be),
    .ls_addr     (ls_addr),
    .ls_wdata    (ls_wdata),
    .ls_ack      (ls_ack),
    .ls_rdata    (ls_rdata),
    .mem_addr    (mem_addr),
    .mem_wr_req  (mem_wr_req),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
  );

  always #5 clk = ~clk;

  // RAM with a backdoor port used only while the controller is quiet
  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_wr_req) ram[mem_addr] <= mem_wr_data;
    mem_rd_data <= ram[mem_addr];
    if (mem_wr_req) n_wr <= n_wr + 1;
    if (ls_ack) n_lsack <= n_lsack + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge_ref(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return r;
  endfunction

  task automatic bd_write(input int wi, input logic [31:0] d);
    bd_we   = 1'b1;
    bd_addr = wi[ADDR_LEN-1:0];
    bd_data = d;
    ref_mem[wi] = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[ADDR_LEN+1:2] = ADDR_LEN'($urandom_range(0, 31));
    return a;
  endfunction

  function automatic logic [3:0] rand_be();
    case ($urandom_range(0, 3))
      0:       return 4'hF;
      1:       return 4'h0;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  // One isolated transaction, started and ended on a falling edge with the DUT idle
  task automatic txn(input bit is_ls, input bit we, input logic [3:0] be,
                     input logic [31:0] addr, input logic [31:0] wd);
    logic [ADDR_LEN-1:0] widx;
    int exp_lat, exp_wr, lat, w0;
    bit got;
    widx    = addr[ADDR_LEN+1:2];
    exp_lat = (is_ls && we && be != 4'hF && be != 4'h0) ? 2 : 1;
    exp_wr  = (is_ls && we && be != 4'h0) ? 1 : 0;
    w0      = n_wr;
    if (is_ls) begin
      ls_req = 1'b1; ls_we = we; ls_be = be; ls_addr = addr; ls_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    #1;
    last_addr = mem_addr;
    chk("addr_c0", 32'(mem_addr), 32'(widx));
    chk("wr_c0", 32'(mem_wr_req), 32'(is_ls && we && be == 4'hF));
    got = 1'b0;
    lat = 0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (is_ls ? ls_ack : if_ack) begin
        got = 1'b1;
        last_rdata = is_ls ? ls_rdata : if_rdata;
        chk("latency", lat, exp_lat);
        chk("other_ack", 32'(is_ls ? if_ack : ls_ack), 0);
        if (is_ls && we) begin
          chk("store_rdata", last_rdata, 0);
          ref_mem[widx] = merge_ref(ref_mem[widx], wd, be);
        end else begin
          chk("rdata", last_rdata, ref_mem[widx]);
        end
        if_req = 1'b0;
        ls_req = 1'b0;
      end
    end
    if (!got) begin
      chk("ack_timeout", 0, 1);
      if_req = 1'b0;
      ls_req = 1'b0;
    end
    chk("wr_count", n_wr - w0, exp_wr);
    @(negedge clk);
    chk("idle_rdata", if_rdata | ls_rdata, 0);
  endtask

  task automatic rand_ls_inputs();
    ls_we    = 1'($urandom_range(0, 1));
    ls_be    = rand_be();
    ls_addr  = rand_addr();
    ls_wdata = $urandom;
  endtask

  initial begin
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h40;
    ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'hF; ls_addr = 32'h44; ls_wdata = 32'hFFFF_FFFF;

    @(negedge clk);
    #1;
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_wr_req", 32'(mem_wr_req), 0);
    chk("rst_wr_data", mem_wr_data, 0);
    chk("rst_acks", 32'({if_ack, ls_ack}), 0);
    chk("rst_rdata", if_rdata | ls_rdata, 0);
    if_req = 1'b0;
    ls_req = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 32; i++) bd_write(i, $urandom);
    bd_write(4, 32'hDEAD_BEEF);
    rst_n = 1'b1;
    @(negedge clk);

    txn(1'b0, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
    chk("fetch_data", last_rdata, 32'hDEAD_BEEF);
    chk("fetch_addr", 32'(last_addr), 4);

    txn(1'b1, 1'b1, 4'hF, 32'h0000_0020, 32'h1234_5678);
    txn(1'b1, 1'b0, 4'h0, 32'h0000_0020, 32'h0);
    chk("load_back", last_rdata, 32'h1234_5678);

    bd_write(8, 32'hAABB_CCDD);
    txn(1'b1, 1'b1, 4'b0010, 32'h0000_0020, 32'h0000_EE00);
    chk("rmw_ram", ram[8], 32'hAABB_EEDD);

    txn(1'b1, 1'b1, 4'h0, 32'h0000_0024, 32'hFFFF_FFFF);
    txn(1'b1, 1'b0, 4'h0, 32'h0000_0024, 32'h0);

    txn(1'b1, 1'b0, 4'h0, 32'h0000_2004, 32'h0);
    chk("wrap_addr", 32'(last_addr), 1);
    chk("wrap_data", last_rdata, ref_mem[1]);

    for (int i = 0; i < 40; i++)
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_be(), rand_addr(), $urandom);

    // Reset landing in the write-back cycle of a partial store
    bd_write(20, 32'h1122_3344);
    acks0 = n_lsack;
    ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'b0100; ls_addr = 32'h0000_0050; ls_wdata = 32'h0099_0000;
    @(posedge clk);
    #2;
    chk("rmw_pre_wr", 32'(mem_wr_req), 1);
    rst_n = 1'b0;
    #1;
    chk("rmw_rst_wr", 32'(mem_wr_req), 0);
    chk("rmw_rst_addr", 32'(mem_addr), 0);
    chk("rmw_rst_wdata", mem_wr_data, 0);
    chk("rmw_rst_acks", 32'({if_ack, ls_ack}), 0);
    chk("rmw_rst_rdata", if_rdata | ls_rdata, 0);
    ls_req = 1'b0;
    @(posedge clk);
    #1;
    chk("rmw_rst_ram", ram[20], 32'h1122_3344);
    @(negedge clk);
    chk("rmw_rst_noack", n_lsack - acks0, 0);
    rst_n = 1'b1;

    // Contention: both requesters always asking, starting from reset
    rand_ls_inputs();
    if_addr = rand_addr();
    ls_req = 1'b1;
    if_req = 1'b1;
    cyc = 0; last_cyc = -1; exp_ls = 1'b1; n_if = 0; n_ls = 0;
    while (n_if + n_ls < 100 && cyc < 800) begin
      @(negedge clk);
      cyc++;
      if (if_ack || ls_ack) begin
        chk("cont_one_ack", 32'(if_ack && ls_ack), 0);
        chk("cont_order", 32'(ls_ack), 32'(exp_ls));
        exp_ls = ~ls_ack;
        if (ls_ack) begin
          idx = int'(ls_addr[ADDR_LEN+1:2]);
          gap = (ls_we && ls_be != 4'hF && ls_be != 4'h0) ? 3 : 2;
          chk("cont_ls_gap", cyc - last_cyc, gap);
          if (ls_we) begin
            chk("cont_st_rdata", ls_rdata, 0);
            ref_mem[idx] = merge_ref(ref_mem[idx], ls_wdata, ls_be);
          end else begin
            chk("cont_ld_rdata", ls_rdata, ref_mem[idx]);
          end
          chk("cont_if_quiet", if_rdata, 0);
          n_ls++;
          rand_ls_inputs();
        end else begin
          idx = int'(if_addr[ADDR_LEN+1:2]);
          chk("cont_if_gap", cyc - last_cyc, 2);
          chk("cont_if_rdata", if_rdata, ref_mem[idx]);
          chk("cont_ls_quiet", ls_rdata, 0);
          n_if++;
          if_addr = rand_addr();
        end
        last_cyc = cyc;
      end
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    chk("cont_total", n_if + n_ls, 100);
    chk("cont_if_n", n_if, 50);
    chk("cont_ls_n", n_ls, 50);
    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < 32; i++) chk("final_ram", ram[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
